// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_t   : arbiter FSM encodings (ST_IDLE / ST_BURST / ST_DONE)
//   owner_t   : requester encodings (OWN_I = 0, OWN_D = 1)
//   line_off_w: byte-offset width of one cache line (low address bits cleared
//               to form a line-aligned burst base)
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic int line_off_w(input int burst_len, input int data_w);
    return $clog2(burst_len * (data_w / 8));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter (purely combinational).
// Ports:
//   req_i      in  I-side request
//   req_d      in  D-side request
//   last_grant in  requester served most recently
//   gnt_valid  out at least one request present
//   gnt        out selected requester (meaningful only when gnt_valid)
// On a tie the requester that was not served last wins.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last_grant,
  output logic   gnt_valid,
  output owner_t gnt
);

  always_comb begin
    gnt_valid = req_i | req_d;
    gnt       = OWN_I;
    if (req_i && req_d) begin
      gnt = (last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (req_d) begin
      gnt = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between I-cache refill (read only) and
// D-cache refill/writeback. One line-sized burst at a time; read beats are
// routed combinationally to the owner, writeback beats come from d_wdata.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_req/i_addr                   I-cache line read request and address
//   i_rdata/i_rvalid/i_done        read beats and completion pulse to I-cache
//   d_req/d_we/d_addr/d_wdata      D-cache burst request, direction, address, write beat
//   d_wnext                        current d_wdata consumed this cycle
//   d_rdata/d_rvalid/d_done        read beats and completion pulse to D-cache
//   mem_req/mem_we/mem_addr/mem_wdata  beat request to memory
//   mem_rdata/mem_ready            beat data / beat completion from memory
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no burst; arbitrate, latch owner/we/base on a grant
// ST_BURST | issue beats; each mem_ready completes one beat
// ST_DONE  | one-cycle done pulse to owner; record owner as last_grant
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wnext,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int BEAT_W     = $clog2(BURST_LEN);
  localparam int BYTES      = DATA_W / 8;
  localparam int LINE_OFF_W = line_off_w(BURST_LEN, DATA_W);

  localparam logic [ADDR_W-1:0] LINE_MASK   = {ADDR_W{1'b1}} << LINE_OFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(BYTES);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q;
  owner_t              owner_q;
  owner_t              last_grant_q;
  logic                we_q;
  logic [ADDR_W-1:0]   base_q;

  logic                gnt_valid;
  owner_t              gnt;
  logic                last_beat;
  logic [ADDR_W-1:0]   beat_addr;

  rr_arb2 u_rr_arb2 (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  // Full-width compare so a non-power-of-two counter width can never alias.
  assign last_beat = (beat_q == LAST_BEAT);
  // base is line aligned, so the beat offset never carries out of the line.
  assign beat_addr = base_q + (ADDR_W'(beat_q) * BEAT_STRIDE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_D;
      we_q         <= 1'b0;
      base_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner_q <= gnt;
            beat_q  <= '0;
            if (gnt == OWN_D) begin
              we_q   <= d_we;
              base_q <= d_addr & LINE_MASK;
            end else begin
              we_q   <= 1'b0;
              base_q <= i_addr & LINE_MASK;
            end
          end
        end
        ST_BURST: begin
          if (mem_ready && !last_beat) begin
            beat_q <= beat_q + 1'b1;
          end
        end
        ST_DONE: begin
          last_grant_q <= owner_q;
          beat_q       <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_rdata   = '0;
    i_rvalid  = 1'b0;
    i_done    = 1'b0;
    d_rdata   = '0;
    d_rvalid  = 1'b0;
    d_done    = 1'b0;
    d_wnext   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = beat_addr;
        // we_q is only ever set for a D grant, so write beats always source d_wdata.
        if (we_q) begin
          mem_wdata = d_wdata;
          d_wnext   = mem_ready;
        end else if (mem_ready) begin
          if (owner_q == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
          end
        end
        if (mem_ready && last_beat) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (owner_q == OWN_D) begin
          d_done = 1'b1;
        end else begin
          i_done = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (BURST_LEN=4, DATA_W=32).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// Memory read data is a fixed function of the beat address.
module tb_mem_port_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 4;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rvalid;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_wnext;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  logic              d_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic [31:0] wb_cnt;
  int          checks;
  int          errors;

  localparam logic [31:0] RD_KEY = 32'hC0DE_0000;
  localparam logic [31:0] WB_KEY = 32'hD0D0_0000;

  assign mem_rdata = mem_addr ^ RD_KEY;
  assign d_wdata   = WB_KEY + wb_cnt;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_rvalid  (i_rvalid),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wnext   (d_wnext),
    .d_rdata   (d_rdata),
    .d_rvalid  (d_rvalid),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the falling edge of the first BURST cycle. Walks the burst
  // with the given mem_ready pattern (LSB first, 1 once exhausted), checks
  // every beat, the DONE pulse and the following IDLE cycle.
  task automatic burst(input logic own, input logic [31:0] base, input logic we,
                       input logic [31:0] pat, input int pat_len,
                       input int raise_i_at, input logic [31:0] raise_addr);
    int   beat;
    int   n;
    logic adv;
    logic [31:0] ea;
    beat = 0;
    n    = 0;
    while (beat < BURST_LEN && n < 40) begin
      mem_ready = (n < pat_len) ? pat[n] : 1'b1;
      if (n == raise_i_at) begin
        i_req  = 1'b1;
        i_addr = raise_addr;
      end
      #1;
      ea = base + 32'(4 * beat);
      chk("mem_req", mem_req, 1);
      chk("mem_we", mem_we, we);
      chk("mem_addr", mem_addr, ea);
      chk("i_rvalid", i_rvalid, (own == 1'b0) && mem_ready && !we);
      chk("d_rvalid", d_rvalid, (own == 1'b1) && mem_ready && !we);
      if (mem_ready && !we) begin
        if (own) chk("d_rdata", d_rdata, ea ^ RD_KEY);
        else     chk("i_rdata", i_rdata, ea ^ RD_KEY);
      end
      if (we) begin
        chk("d_wnext", d_wnext, mem_ready);
        chk("mem_wdata", mem_wdata, WB_KEY + wb_cnt);
      end else begin
        chk("d_wnext_rd", d_wnext, 0);
      end
      chk("done_in_burst", {i_done, d_done}, 0);
      adv = mem_ready;
      cyc();
      if (adv) begin
        beat++;
        if (we) wb_cnt++;
      end
      n++;
    end
    if (beat < BURST_LEN) chk("burst_timeout", 64'(beat), 64'(BURST_LEN));
    if (own) d_req = 1'b0;
    else     i_req = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("i_done", i_done, !own);
    chk("d_done", d_done, own);
    chk("done_mem_req", mem_req, 0);
    chk("done_rvalid", {i_rvalid, d_rvalid, d_wnext}, 0);
    cyc();
    #1;
    chk("idle_done", {i_done, d_done}, 0);
    chk("idle_mem_req", mem_req, 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    wb_cnt    = '0;
    rst       = 1'b1;
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    mem_ready = 1'b0;
    cyc();
    cyc();
    #1;
    chk("rst_mem", {mem_req, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    chk("rst_flags", {i_rvalid, d_rvalid, i_done, d_done, d_wnext}, 0);

    // 1: single I refill, mem_ready always high.
    rst       = 1'b0;
    i_req     = 1'b1;
    i_addr    = 32'h1004;
    mem_ready = 1'b1;
    #1;
    chk("t1_idle", mem_req, 0);
    cyc();
    burst(1'b0, 32'h1000, 1'b0, 32'hF, 4, -1, 0);

    // 1b: last grant was I, so a tie now goes to D, then I.
    i_req  = 1'b1;
    i_addr = 32'h1208;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h3044;
    cyc();
    burst(1'b1, 32'h3040, 1'b0, 32'hF, 4, -1, 0);
    cyc();
    burst(1'b0, 32'h1200, 1'b0, 32'hF, 4, -1, 0);

    // 2: tie out of reset goes to I, D follows after one IDLE cycle,
    //    next tie goes to I again.
    rst = 1'b1;
    cyc();
    rst    = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h1100;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h3000;
    cyc();
    burst(1'b0, 32'h1100, 1'b0, 32'hF, 4, -1, 0);
    cyc();
    burst(1'b1, 32'h3000, 1'b0, 32'hF, 4, -1, 0);
    i_req  = 1'b1;
    i_addr = 32'h1140;
    d_req  = 1'b1;
    d_addr = 32'h3080;
    cyc();
    burst(1'b0, 32'h1140, 1'b0, 32'hF, 4, -1, 0);
    cyc();
    burst(1'b1, 32'h3080, 1'b0, 32'hF, 4, -1, 0);

    // 3: D writeback with stalls, ready pattern 1,0,0,1,1,0,1.
    d_req  = 1'b1;
    d_we   = 1'b1;
    d_addr = 32'h2010;
    cyc();
    burst(1'b1, 32'h2010, 1'b1, 32'h59, 7, -1, 0);

    // 4: D refill, i_req rises on the second cycle of the burst.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h6020;
    cyc();
    burst(1'b1, 32'h6020, 1'b0, 32'h2D, 6, 1, 32'h7030);
    cyc();
    burst(1'b0, 32'h7030, 1'b0, 32'hF, 4, -1, 0);

    // 5: reset on beat 2 of an I burst, then a fresh tie restarts at beat 0
    //    with I first (last_grant back to D).
    i_req     = 1'b1;
    i_addr    = 32'h8000;
    mem_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    #1;
    chk("t5_beat2_addr", mem_addr, 32'h8008);
    rst   = 1'b1;
    i_req = 1'b0;
    cyc();
    #1;
    chk("t5_rst_mem_req", mem_req, 0);
    chk("t5_rst_flags", {i_done, i_rvalid, d_done, d_rvalid}, 0);
    rst = 1'b0;
    cyc();
    #1;
    chk("t5_idle", {mem_req, i_done}, 0);
    i_req  = 1'b1;
    i_addr = 32'h800C;
    d_req  = 1'b1;
    d_we   = 1'b1;
    d_addr = 32'h9000;
    cyc();
    burst(1'b0, 32'h8000, 1'b0, 32'hF, 4, -1, 0);
    cyc();
    burst(1'b1, 32'h9000, 1'b1, 32'hF, 4, -1, 0);

    // 6: back-to-back D bursts alternating refill/writeback.
    for (int k = 0; k < 4; k++) begin
      logic [31:0] pat;
      int          plen;
      case (k)
        0:       begin pat = 32'h0F; plen = 4; end
        1:       begin pat = 32'h55; plen = 7; end
        2:       begin pat = 32'h36; plen = 6; end
        default: begin pat = 32'h0F; plen = 4; end
      endcase
      cyc();
      d_req  = 1'b1;
      d_we   = k[0];
      d_addr = 32'h5000 + 32'(k * 32'h40) + 32'h8;
      cyc();
      burst(1'b1, 32'h5000 + 32'(k * 32'h40), k[0], pat, plen, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
